// File: rtl/serial_word_deserializer_if.sv
// Serial-in / word-out bundle between a bit source and the word consumer.
// The master drives the serial side and the slave produces the word side.
interface serial_word_deserializer_if #(
    parameter int WIDTH = 16
);
    localparam int LW = $clog2(WIDTH) + 1;

    logic             data_i;
    logic             data_val_i;
    logic             flush_i;
    logic [WIDTH-1:0] deser_data_o;
    logic [LW-1:0]    deser_len_o;
    logic             deser_data_val_o;

    modport master (
        output data_i, data_val_i, flush_i,
        input  deser_data_o, deser_len_o, deser_data_val_o
    );

    modport slave (
        input  data_i, data_val_i, flush_i,
        output deser_data_o, deser_len_o, deser_data_val_o
    );
endinterface

// File: rtl/serial_word_deserializer.sv
// Packs an MSB-first serial stream into WIDTH-bit words; flush emits a
// zero-padded partial word together with its bit count.
module serial_word_deserializer #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         srst_i,
    serial_word_deserializer_if.slave    bus
);
    localparam int LW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LW-1:0]    LAST    = LW'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]    len_q, len_d;
    logic             val_q, val_d;

    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] sr_acc;
    logic [LW-1:0]    n_eff;
    logic             complete;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        data_d = data_q;
        len_d = len_q;
        val_d = 1'b0;

        // Word including this cycle's bit, so a coincident flush or completion sees it.
        mask     = MSB_ONE >> cnt_q;
        sr_acc   = sr_q;
        if (bus.data_val_i)
            sr_acc = (sr_q & ~mask) | (mask & {WIDTH{bus.data_i}});
        n_eff    = cnt_q + LW'(bus.data_val_i);
        complete = bus.data_val_i && (cnt_q == LAST);

        if (complete || (bus.flush_i && n_eff != '0)) begin
            val_d  = 1'b1;
            data_d = sr_acc;
            len_d  = n_eff;
            sr_d   = '0;
            cnt_d  = '0;
        end else if (bus.data_val_i) begin
            sr_d  = sr_acc;
            cnt_d = cnt_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge srst_i) begin
        if (!srst_i) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            len_q  <= '0;
            val_q  <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            len_q  <= len_d;
            val_q  <= val_d;
        end
    end

    assign bus.deser_data_o     = data_q;
    assign bus.deser_len_o      = len_q;
    assign bus.deser_data_val_o = val_q;
endmodule
